id_ex_stage: RTL
================

# id_ex_stage

Decode-to-execute pipeline stage that feeds the ALU. It captures decoded instructions through a valid/ready handshake and resolves operand B (register or immediate). It holds up to two instructions in a skid buffer so back-pressure from execute never creates a combinational ready path to decode, and it presents registered `ALUCtrl`/`ALUOpA`/`ALUOpB` to the ALU.

## Interface
Parameters:
- `WIDTH`, 32, datapath width.
- `REG_ADDR_WIDTH`, 5, register-file address width.

Ports:
- `clk`  in  1  single clock, all state updates on rising edge.
- `reset`  in  1  synchronous, active-high.
- `DecValid`  in  1  decode presents an instruction.
- `DecReady`  out  1  stage can accept this cycle.
- `DecALUCtrl`  in  `HighLevelControl::aluOperation`  ALU operation.
- `DecRs1Val`, `DecRs2Val`  in  `WIDTH`  register-file read values.
- `DecImm`  in  `WIDTH`  sign-extended immediate.
- `DecUseImm`  in  1  operand B = immediate.
- `DecRs1Addr`, `DecRs2Addr`, `DecRdAddr`  in  `REG_ADDR_WIDTH`  source/destination registers.
- `DecRegWrite`  in  1  instruction writes `rd`.
- `Flush`  in  1  kill all held instructions (branch redirect).
- `ExValid`  out  1  ALU operands valid.
- `ExReady`  in  1  execute consumes the head entry.
- `ALUCtrl`  out  `aluOperation`; `ALUOpA`, `ALUOpB`  out  `WIDTH`  ALU inputs.
- `ExRdAddr`  out  `REG_ADDR_WIDTH`; `ExRegWrite`  out  1.
- `WbRegWrite`  in  1; `WbRdAddr`  in  `REG_ADDR_WIDTH`; `WbData`  in  `WIDTH`  writeback snoop. Present only with `ID_EX_FORWARD_EN`.

## Operation
- Two entries: HEAD drives the outputs, SKID is the overflow entry. State is EMPTY, ONE, or TWO.
- Accept is `DecValid && DecReady`. Drain is `ExValid && ExReady`.
- `DecReady = !reset && state != TWO`. It is a function of registered state only.
- `ExValid = (state != EMPTY)`.
- Operand resolution at capture: OpA = `DecRs1Val`; OpB = `DecUseImm ? DecImm : DecRs2Val`.
- Transitions:
  - EMPTY + accept → ONE, with the new entry in HEAD.
  - ONE + accept, no drain → TWO, with the new entry in SKID.
  - ONE + accept + drain → ONE, with the new entry in HEAD.
  - ONE + drain, no accept → EMPTY.
  - TWO + drain → ONE, SKID moves to HEAD. Accept is impossible in TWO because `DecReady` = 0.
- `Flush` takes priority over all other events. The next state is EMPTY and any same-cycle accept is discarded. `DecReady` is unaffected in the flush cycle.
- Reset behaviour:
  - State returns to EMPTY.
  - `ExValid` = 0, `DecReady` = 0.
  - `ALUCtrl` = `ADD`, `ALUOpA` = `ALUOpB` = 0, `ExRdAddr` = 0, `ExRegWrite` = 0.
  - Reset mid-operation discards both entries.
- Data outputs hold HEAD contents while `ExValid` = 0. Execute ignores them.
- Once `ExValid` is asserted, it and all data outputs stay stable until drain, except on `Flush`, reset, or a forwarding update.

## Timing
- Latency: an instruction accepted at edge N appears on outputs after edge N, so `ExValid` is high in cycle N+1.
- Throughput: 1 instruction/cycle while `ExReady` = 1.
- A single-cycle `ExReady` deassertion costs no bubble because SKID absorbs it.
- No combinational path from `ExReady` to `DecReady`.
- No combinational path from `Dec*` to `Ex*` outputs.

## Configuration
- `ID_EX_FORWARD_EN` defined:
  - Add the `Wb*` ports.
  - At capture, if `WbRegWrite && WbRdAddr != 0 && WbRdAddr == DecRs1Addr`, then OpA = `WbData`. The same rule applies to rs2 for OpB when `!DecUseImm`.
  - Each cycle, held HEAD/SKID entries also snoop the same comparison against their stored rs addresses and overwrite OpA/OpB. Held entries therefore never miss a writeback while stalled.
  - Entries store rs1/rs2 addresses and `UseImm` for this purpose.
- `ID_EX_FORWARD_EN` undefined: no `Wb*` ports, no stored source addresses, operands are never modified after capture.

## Structure
- `HighLevelControl` package:
  - Already holds `aluOperation`.
  - Add `idExEntry` struct: ctrl, opA, opB, rdAddr, regWrite, and, under the macro, rs1Addr, rs2Addr, useImm.
  - Add the state enum `idExState` {EMPTY, ONE, TWO}.
- Sub-module `operand_snoop`: combinational per-entry forwarding comparator and mux. Instantiated three times (capture path, HEAD, SKID); compiled only under the macro.

## Test plan
- Stream: `ExReady` = 1, issue ADD 5+7 then SUB 9−4 back-to-back → `ExValid` high cycles 1–2 with (`ADD`, 5, 7) then (`SUB`, 9, 4). `DecReady` stays 1.
- Back-pressure: `ExReady` = 0, accept 3 instructions.
  - State reaches TWO and `DecReady` = 0 after 2 accepts.
  - The 3rd is held at decode.
  - Raising `ExReady` drains entries in order with no loss or duplication.
- Immediate: `DecUseImm` = 1, `DecImm` = 0xFFFFFFF0, `DecRs2Val` = 3 → `ALUOpB` = 0xFFFFFFF0.
- Flush in TWO, with `DecValid` = 1 the same cycle → next cycle `ExValid` = 0 and the state is EMPTY. The flushed-cycle instruction is never seen at the outputs.
- Reset asserted mid-stream → next cycle `ExValid` = 0, `DecReady` = 0, `ALUOpA` = `ALUOpB` = 0, `ExRegWrite` = 0.
- (`ID_EX_FORWARD_EN`) Hold an entry with rs1 = x5, stale value 1, `ExReady` = 0. Pulse `WbRegWrite`, `WbRdAddr` = 5, `WbData` = 0x1234 → `ALUOpA` = 0x1234 next cycle. The same pulse with `WbRdAddr` = 0 leaves `ALUOpA` unchanged.

Source files
------------

// File: rtl/HighLevelControl_pkg.sv
// rtl/HighLevelControl_pkg.sv - ALU operation, decode/execute entry and stage state types.
// Entry source-address fields exist only when ID_EX_FORWARD_EN is defined.
package HighLevelControl;

  localparam int ID_EX_WIDTH          = 32;
  localparam int ID_EX_REG_ADDR_WIDTH = 5;

  typedef enum logic [3:0] {
    ADD  = 4'd0,
    SUB  = 4'd1,
    AND  = 4'd2,
    OR   = 4'd3,
    XOR  = 4'd4,
    SLL  = 4'd5,
    SRL  = 4'd6,
    SRA  = 4'd7,
    SLT  = 4'd8,
    SLTU = 4'd9
  } aluOperation;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } idExState;

  typedef struct packed {
    aluOperation                     ctrl;
    logic [ID_EX_WIDTH-1:0]          opA;
    logic [ID_EX_WIDTH-1:0]          opB;
    logic [ID_EX_REG_ADDR_WIDTH-1:0] rdAddr;
    logic                            regWrite;
`ifdef ID_EX_FORWARD_EN
    logic [ID_EX_REG_ADDR_WIDTH-1:0] rs1Addr;
    logic [ID_EX_REG_ADDR_WIDTH-1:0] rs2Addr;
    logic                            useImm;
`endif
  } idExEntry;

  function automatic logic [ID_EX_WIDTH-1:0] resolve_op_b(
    input logic                   use_imm,
    input logic [ID_EX_WIDTH-1:0] imm,
    input logic [ID_EX_WIDTH-1:0] rs2_val
  );
    return use_imm ? imm : rs2_val;
  endfunction

  // Reset image presented on the ALU inputs: ADD with zero operands.
  function automatic idExEntry id_ex_reset_entry();
    idExEntry e;
    e      = '0;
    e.ctrl = ADD;
    return e;
  endfunction

endpackage

// File: rtl/id_ex_stage_operand_snoop.sv
// rtl/id_ex_stage_operand_snoop.sv - writeback snoop comparator/mux for one entry (ID_EX_FORWARD_EN only).
`ifdef ID_EX_FORWARD_EN
module operand_snoop #(
  parameter int WIDTH          = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic [REG_ADDR_WIDTH-1:0] rs1Addr,
  input  logic [REG_ADDR_WIDTH-1:0] rs2Addr,
  input  logic                      useImm,
  input  logic [WIDTH-1:0]          opAIn,
  input  logic [WIDTH-1:0]          opBIn,
  input  logic                      WbRegWrite,
  input  logic [REG_ADDR_WIDTH-1:0] WbRdAddr,
  input  logic [WIDTH-1:0]          WbData,
  output logic [WIDTH-1:0]          opAOut,
  output logic [WIDTH-1:0]          opBOut
);

  logic wb_live;
  logic hit_a;
  logic hit_b;

  // x0 is hardwired, so a write to it never forwards.
  assign wb_live = WbRegWrite && (WbRdAddr != '0);
  assign hit_a   = wb_live && (WbRdAddr == rs1Addr);
  assign hit_b   = wb_live && (WbRdAddr == rs2Addr) && !useImm;

  assign opAOut  = hit_a ? WbData : opAIn;
  assign opBOut  = hit_b ? WbData : opBIn;

endmodule
`endif

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - two-entry skid-buffered decode-to-execute stage feeding the ALU.
// Define ID_EX_FORWARD_EN to add writeback snooping on captured and held operands.
module id_ex_stage
  import HighLevelControl::*;
#(
  parameter int WIDTH          = ID_EX_WIDTH,
  parameter int REG_ADDR_WIDTH = ID_EX_REG_ADDR_WIDTH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      DecValid,
  output logic                      DecReady,
  input  aluOperation               DecALUCtrl,
  input  logic [WIDTH-1:0]          DecRs1Val,
  input  logic [WIDTH-1:0]          DecRs2Val,
  input  logic [WIDTH-1:0]          DecImm,
  input  logic                      DecUseImm,
  input  logic [REG_ADDR_WIDTH-1:0] DecRs1Addr,
  input  logic [REG_ADDR_WIDTH-1:0] DecRs2Addr,
  input  logic [REG_ADDR_WIDTH-1:0] DecRdAddr,
  input  logic                      DecRegWrite,
  input  logic                      Flush,
  output logic                      ExValid,
  input  logic                      ExReady,
  output aluOperation               ALUCtrl,
  output logic [WIDTH-1:0]          ALUOpA,
  output logic [WIDTH-1:0]          ALUOpB,
  output logic [REG_ADDR_WIDTH-1:0] ExRdAddr,
  output logic                      ExRegWrite
`ifdef ID_EX_FORWARD_EN
  ,
  input  logic                      WbRegWrite,
  input  logic [REG_ADDR_WIDTH-1:0] WbRdAddr,
  input  logic [WIDTH-1:0]          WbData
`endif
);

  idExState state_q, state_d;
  idExEntry head_q, head_d, skid_q, skid_d;
  idExEntry cap_raw, cap, head_s, skid_s;
  logic     accept, drain;

  always_comb begin
    cap_raw          = '0;
    cap_raw.ctrl     = DecALUCtrl;
    cap_raw.opA      = DecRs1Val;
    cap_raw.opB      = resolve_op_b(DecUseImm, DecImm, DecRs2Val);
    cap_raw.rdAddr   = DecRdAddr;
    cap_raw.regWrite = DecRegWrite;
`ifdef ID_EX_FORWARD_EN
    cap_raw.rs1Addr  = DecRs1Addr;
    cap_raw.rs2Addr  = DecRs2Addr;
    cap_raw.useImm   = DecUseImm;
`endif
  end

`ifdef ID_EX_FORWARD_EN
  logic [WIDTH-1:0] cap_opa, cap_opb, head_opa, head_opb, skid_opa, skid_opb;

  operand_snoop #(.WIDTH(WIDTH), .REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_snoop_cap (
    .rs1Addr(cap_raw.rs1Addr), .rs2Addr(cap_raw.rs2Addr), .useImm(cap_raw.useImm),
    .opAIn(cap_raw.opA), .opBIn(cap_raw.opB),
    .WbRegWrite(WbRegWrite), .WbRdAddr(WbRdAddr), .WbData(WbData),
    .opAOut(cap_opa), .opBOut(cap_opb)
  );

  operand_snoop #(.WIDTH(WIDTH), .REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_snoop_head (
    .rs1Addr(head_q.rs1Addr), .rs2Addr(head_q.rs2Addr), .useImm(head_q.useImm),
    .opAIn(head_q.opA), .opBIn(head_q.opB),
    .WbRegWrite(WbRegWrite), .WbRdAddr(WbRdAddr), .WbData(WbData),
    .opAOut(head_opa), .opBOut(head_opb)
  );

  operand_snoop #(.WIDTH(WIDTH), .REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_snoop_skid (
    .rs1Addr(skid_q.rs1Addr), .rs2Addr(skid_q.rs2Addr), .useImm(skid_q.useImm),
    .opAIn(skid_q.opA), .opBIn(skid_q.opB),
    .WbRegWrite(WbRegWrite), .WbRdAddr(WbRdAddr), .WbData(WbData),
    .opAOut(skid_opa), .opBOut(skid_opb)
  );

  always_comb begin
    cap        = cap_raw;
    cap.opA    = cap_opa;
    cap.opB    = cap_opb;
    head_s     = head_q;
    head_s.opA = head_opa;
    head_s.opB = head_opb;
    skid_s     = skid_q;
    skid_s.opA = skid_opa;
    skid_s.opB = skid_opb;
  end
`else
  logic unused_rs_addr;
  assign unused_rs_addr = ^{DecRs1Addr, DecRs2Addr};

  assign cap    = cap_raw;
  assign head_s = head_q;
  assign skid_s = skid_q;
`endif

  // Ready depends only on registered state, so ExReady never reaches DecReady.
  assign DecReady = !reset && (state_q != TWO);
  assign ExValid  = (state_q != EMPTY);
  assign accept   = DecValid && DecReady;
  assign drain    = ExValid && ExReady;

  always_comb begin
    state_d = state_q;
    head_d  = (state_q != EMPTY) ? head_s : head_q;
    skid_d  = (state_q == TWO)   ? skid_s : skid_q;
    if (Flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            head_d  = cap;
            state_d = ONE;
          end
        end
        ONE: begin
          if (accept && drain) begin
            head_d  = cap;
          end else if (accept) begin
            skid_d  = cap;
            state_d = TWO;
          end else if (drain) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (drain) begin
            head_d  = skid_s;
            state_d = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
      head_q  <= id_ex_reset_entry();
      skid_q  <= id_ex_reset_entry();
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
    end
  end

  assign ALUCtrl    = head_q.ctrl;
  assign ALUOpA     = head_q.opA;
  assign ALUOpB     = head_q.opB;
  assign ExRdAddr   = head_q.rdAddr;
  assign ExRegWrite = head_q.regWrite;

endmodule
